gpio_event_log: RTL and testbench



---
 rtl/gpio_event_log_pkg.sv | 17 +
 rtl/gpio_event_fifo.sv | 55 +++++
 rtl/gpio_event_log.sv | 97 +++++++++
 tb/tb_gpio_event_log.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_event_log_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_event_log_pkg: shared constants and record-width helper         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gpio_event_log_pkg;

  localparam int DefaultDepth   = 8;
  localparam int DefaultTsWidth = 16;
  localparam int DropCntWidth   = 8;

  function automatic int record_width(input int ts_width, input int width);
    return ts_width + width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_event_fifo: synchronous first-word-fall-through record FIFO     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gpio_event_fifo #(
  parameter int Depth     = 8,
  parameter int DataWidth = 48
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DataWidth-1:0]   wdata,
  output logic [DataWidth-1:0]   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] level
);

  localparam int            c_aw    = $clog2(Depth);
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(Depth);

  logic [c_aw:0]          r_wptr;
  logic [c_aw:0]          r_rptr;
  logic [DataWidth-1:0]   r_mem [Depth];
  logic                   w_do_push;
  logic                   w_do_pop;

  // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
  assign w_do_push = push & (~full | pop);
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (c_aw + 1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (c_aw + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push && !flush) r_mem[r_wptr[c_aw-1:0]] <= wdata;
  end

  assign level = r_wptr - r_rptr;
  assign full  = (level == c_depth);
  assign empty = (level == '0);
  assign rdata = r_mem[r_rptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/gpio_event_log.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_event_log: timestamped change logger for synchronized GPIO pins |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gpio_event_log
  import gpio_event_log_pkg::*;
#(
  parameter int Width   = 32,
  parameter int Depth   = DefaultDepth,
  parameter int TsWidth = DefaultTsWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [Width-1:0]        gpio_i,
  input  logic [Width-1:0]        en_mask_i,
  input  logic                    clear_i,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [TsWidth-1:0]      evt_ts_o,
  output logic [Width-1:0]        evt_pins_o,
  output logic [$clog2(Depth):0]  level_o,
  output logic                    overflow_o,
  output logic [DropCntWidth-1:0] drop_cnt_o
);

  localparam int                      c_rec_w    = record_width(TsWidth, Width);
  localparam logic [DropCntWidth-1:0] c_drop_max = '1;

  logic [Width-1:0]        r_sync1;
  logic [Width-1:0]        r_sync2;
  logic [Width-1:0]        r_last;
  logic [TsWidth-1:0]      r_ts;
  logic                    r_overflow;
  logic [DropCntWidth-1:0] r_drop_cnt;

  logic                    w_change;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;
  logic [c_rec_w-1:0]      w_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_last  <= '0;
      r_ts    <= '0;
    end else begin
      r_sync1 <= gpio_i;
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      r_ts    <= r_ts + TsWidth'(1);
    end
  end

  assign w_change = |((r_sync2 ^ r_last) & en_mask_i);
  assign w_pop    = ~w_empty & evt_ready_i;
  assign w_push   = w_change & ~clear_i;
  assign w_drop   = w_push & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != c_drop_max) r_drop_cnt <= r_drop_cnt + DropCntWidth'(1);
    end
  end

  gpio_event_fifo #(
    .Depth     (Depth),
    .DataWidth (c_rec_w)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (w_push),
    .pop   (w_pop),
    .flush (clear_i),
    .wdata ({r_ts, r_sync2}),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (level_o)
  );

  assign evt_valid_o = ~w_empty;
  assign evt_ts_o    = w_rdata[c_rec_w-1 -: TsWidth];
  assign evt_pins_o  = w_rdata[Width-1:0];
  assign overflow_o  = r_overflow;
  assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gpio_event_log.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_event_log: scoreboard bench for gpio_event_log               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gpio_event_log;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] gpio = '0;
  logic [31:0] mask = '0;
  logic        clr = 1'b0;
  logic        ready = 1'b0;
  logic        valid;
  logic [15:0] ev_ts;
  logic [31:0] ev_pins;
  logic [3:0]  level;
  logic        ovf;
  logic [7:0]  drops;

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_q[$];
  logic [15:0] ts_m;
  logic [31:0] gpio_prev = '0;

  always #5 clk = ~clk;

  gpio_event_log #(.Width(32), .Depth(8), .TsWidth(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .gpio_i      (gpio),
    .en_mask_i   (mask),
    .clear_i     (clr),
    .evt_valid_o (valid),
    .evt_ready_i (ready),
    .evt_ts_o    (ev_ts),
    .evt_pins_o  (ev_pins),
    .level_o     (level),
    .overflow_o  (ovf),
    .drop_cnt_o  (drops)
  );

  // Reference timestamp: counts edges since reset release.
  always @(posedge clk) begin
    if (rst) ts_m <= '0;
    else     ts_m <= ts_m + 16'd1;
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive new pad value; the record lands with timestamp ts_m+2.
  task automatic drive(input logic [31:0] g, input bit accept);
    gpio = g;
    if ((((g ^ gpio_prev) & mask) != 0) && accept)
      exp_q.push_back({ts_m + 16'd2, g});
    gpio_prev = g;
  endtask

  task automatic drain(input bit random_ready);
    int n = 0;
    while (level != 0 && n < 300) begin
      ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    ready = 1'b0;
    check("drain_done", 48'(level), 48'd0);
  endtask

  // Monitor: head record must always equal the oldest expected record.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", {ev_ts, ev_pins}, 48'hDEAD);
      end else begin
        check("rec_ts", 48'(ev_ts), 48'(exp_q[0][47:32]));
        check("rec_pins", 48'(ev_pins), 48'(exp_q[0][31:0]));
        if (ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 48'(valid), 48'd0);
    check("rst_level", 48'(level), 48'd0);
    check("rst_ovf", 48'(ovf), 48'd0);
    check("rst_drops", 48'(drops), 48'd0);

    // Single edge with detect-cycle timestamp 10, 3-edge latency.
    mask = 32'h1;
    step();
    while (ts_m != 16'd8) step();
    drive(32'h1, 1'b1);
    step();
    step();
    @(negedge clk);
    check("lat_early_valid", 48'(valid), 48'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid", 48'(valid), 48'd1);
    check("lat_ts10", 48'(ev_ts), 48'd10);
    check("lat_level", 48'(level), 48'd1);
    step();
    drain(1'b0);

    // Masked pin produces nothing; later record shows its level.
    drive(32'h21, 1'b1);
    repeat (5) step();
    check("masked_level", 48'(level), 48'd0);
    drive(32'h20, 1'b1);
    repeat (4) step();
    check("unmask_level", 48'(level), 48'd1);
    check("unmask_pins", 48'(ev_pins), 48'h20);
    drain(1'b0);

    // Overflow: 10 edges into depth 8 without draining.
    for (int i = 0; i < 10; i++) begin
      drive(gpio ^ 32'h1, i < 8);
      step();
    end
    repeat (3) step();
    check("ovf_level", 48'(level), 48'd8);
    check("ovf_flag", 48'(ovf), 48'd1);
    check("ovf_drops", 48'(drops), 48'd2);
    drain(1'b0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) begin
      drive(gpio ^ 32'h1, 1'b1);
      step();
    end
    repeat (3) step();
    check("full_level", 48'(level), 48'd8);
    drive(gpio ^ 32'h1, 1'b1);
    step();
    step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    check("pushpop_level", 48'(level), 48'd8);
    check("pushpop_drops", 48'(drops), 48'd2);
    drain(1'b0);

    // Timestamp wrap with back-to-back edges, random backpressure on drain.
    n = 0;
    while (ts_m != 16'hFFFD && n < 70000) begin
      step();
      n++;
    end
    check("wrap_reached", 48'(ts_m), 48'hFFFD);
    for (int i = 0; i < 4; i++) begin
      drive(gpio ^ 32'h1, 1'b1);
      step();
    end
    repeat (3) step();
    check("wrap_head_ts", 48'(ev_ts), 48'hFFFF);
    check("wrap_level", 48'(level), 48'd4);
    drain(1'b1);

    // Saturating drop counter, then clear colliding with a change.
    for (int i = 0; i < 308; i++) begin
      drive(gpio ^ 32'h1, i < 8);
      step();
    end
    repeat (3) step();
    check("sat_drops", 48'(drops), 48'd255);
    check("sat_ovf", 48'(ovf), 48'd1);
    check("sat_level", 48'(level), 48'd8);
    drive(gpio ^ 32'h1, 1'b0);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_q.delete();
    check("clr_level", 48'(level), 48'd0);
    check("clr_ovf", 48'(ovf), 48'd0);
    check("clr_drops", 48'(drops), 48'd0);
    repeat (5) step();
    check("clr_no_record", 48'(valid), 48'd0);
    check("clr_level_late", 48'(level), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
